// File: rtl/transpose_stream_ctrl.sv
// transpose_stream_ctrl: credit-based flow control between the input FIFO, the
// 32x32 transpose core and the output FIFO, with a zero-row drain on flush.
module transpose_stream_ctrl #(
    parameter int BEATS          = 32,
    parameter int ROW_CNT_W      = 5,
    parameter int OUT_DEPTH_BITS = 3,
    parameter int MAT_CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_fifo_empty,
    output logic                 in_fifo_re,
    output logic                 core_en,
    output logic                 core_zero,
    input  logic                 core_valid,
    output logic                 out_fifo_we,
    input  logic                 out_fifo_re,
    input  logic                 flush,
    output logic                 busy,
    output logic                 done,
    output logic [MAT_CNT_W-1:0] matrix_count
);
    localparam int OCC_W = OUT_DEPTH_BITS + 1;
    localparam int DRN_W = ROW_CNT_W + 1;
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(1 << OUT_DEPTH_BITS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic [ROW_CNT_W-1:0]   row_cnt_q, row_cnt_d;
    logic [DRN_W-1:0]       drain_cnt_q, drain_cnt_d;
    logic [MAT_CNT_W-1:0]   mat_cnt_q, mat_cnt_d;
    logic                   flush_pend_q, flush_pend_d;
    logic                   core_en_q, core_en_d;
    logic                   core_zero_q, core_zero_d;
    logic                   credit_ok, drain_issue, row_last, pop;

    // The beat currently in the core counts against credit before it is written.
    assign credit_ok   = (occ_q + OCC_W'(core_en_q)) < OCC_MAX;
    assign in_fifo_re  = (state_q == RUN) & ~in_fifo_empty & credit_ok;
    assign drain_issue = (state_q == DRAIN) & credit_ok &
                         ((drain_cnt_q + DRN_W'(core_en_q)) < DRN_W'(BEATS));
    assign row_last    = row_cnt_q == ROW_CNT_W'(BEATS - 1);
    assign pop         = out_fifo_re & (occ_q != '0);

    assign core_en      = core_en_q;
    assign core_zero    = core_zero_q;
    assign out_fifo_we  = core_en_q & core_valid;
    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
    assign matrix_count = mat_cnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = (flush && mat_cnt_q == '0) ? DONE : (!in_fifo_empty ? RUN : IDLE);
            RUN:   state_d = (flush_pend_q && in_fifo_empty && row_cnt_q == '0 && !core_en_q && !in_fifo_re) ? DRAIN : RUN;
            DRAIN: state_d = (core_en_q && drain_cnt_q == DRN_W'(BEATS - 1)) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
        occ_d        = (out_fifo_we && !pop) ? occ_q + 1'b1 : ((!out_fifo_we && pop) ? occ_q - 1'b1 : occ_q);
        row_cnt_d    = (state_q == DONE) ? '0 : (core_en_q ? (row_last ? '0 : row_cnt_q + 1'b1) : row_cnt_q);
        drain_cnt_d  = (state_q != DRAIN) ? '0 : drain_cnt_q + DRN_W'(core_en_q);
        mat_cnt_d    = (core_en_q && row_last && state_q == RUN) ? mat_cnt_q + 1'b1 : mat_cnt_q;
        flush_pend_d = (state_q == DONE) ? 1'b0 : (flush_pend_q | flush);
        core_en_d    = in_fifo_re | drain_issue;
        core_zero_d  = drain_issue;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            occ_q        <= '0;
            row_cnt_q    <= '0;
            drain_cnt_q  <= '0;
            mat_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            core_en_q    <= 1'b0;
            core_zero_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            occ_q        <= occ_d;
            row_cnt_q    <= row_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            mat_cnt_q    <= mat_cnt_d;
            flush_pend_q <= flush_pend_d;
            core_en_q    <= core_en_d;
            core_zero_q  <= core_zero_d;
        end
    end
endmodule

// File: tb/tb_transpose_stream_ctrl.sv
// tb_transpose_stream_ctrl: directed scenarios against models of the input FIFO,
// the transpose core's valid output and the output FIFO occupancy.
module tb_transpose_stream_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_fifo_empty, in_fifo_re, core_en, core_zero, core_valid;
    logic        out_fifo_we, out_fifo_re = 1'b0, flush = 1'b0, busy, done;
    logic [15:0] matrix_count;
    int pushed = 0, popped = 0, rows_total, ocnt, max_ocnt = 0;
    int n_en = 0, n_we = 0, n_zero = 0, n_done = 0, n_re = 0;
    bit force_valid = 1'b0;
    int checks = 0, errors = 0;

    transpose_stream_ctrl dut (
        .clk(clk), .reset(rst_n), .in_fifo_empty(in_fifo_empty), .in_fifo_re(in_fifo_re),
        .core_en(core_en), .core_zero(core_zero), .core_valid(core_valid),
        .out_fifo_we(out_fifo_we), .out_fifo_re(out_fifo_re), .flush(flush),
        .busy(busy), .done(done), .matrix_count(matrix_count)
    );

    always #5 clk = ~clk;

    // Core emits a valid transposed row once it has absorbed a full matrix.
    assign in_fifo_empty = (pushed == popped);
    assign core_valid    = core_en && (rows_total >= 32 || force_valid);

    always @(posedge clk) begin
        if (in_fifo_re) popped <= popped + 1;
        n_en   <= n_en + int'(core_en);
        n_we   <= n_we + int'(out_fifo_we);
        n_zero <= n_zero + int'(core_zero);
        n_done <= n_done + int'(done);
        n_re   <= n_re + int'(in_fifo_re);
        if (ocnt > max_ocnt) max_ocnt <= ocnt;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_total <= 0;
            ocnt       <= 0;
        end else begin
            rows_total <= rows_total + int'(core_en);
            if (out_fifo_we && !(out_fifo_re && ocnt != 0)) ocnt <= ocnt + 1;
            else if (!out_fifo_we && out_fifo_re && ocnt != 0) ocnt <= ocnt - 1;
        end
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_done(input int limit, output int lat);
        lat = 0;
        while (!done && lat < limit) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        wait_cycles(3);
        checks += 7;
        if (in_fifo_re !== 1'b0) begin errors++; $display("FAIL rst_in_fifo_re got %b exp 0", in_fifo_re); end
        if (core_en !== 1'b0) begin errors++; $display("FAIL rst_core_en got %b exp 0", core_en); end
        if (core_zero !== 1'b0) begin errors++; $display("FAIL rst_core_zero got %b exp 0", core_zero); end
        if (out_fifo_we !== 1'b0) begin errors++; $display("FAIL rst_out_fifo_we got %b exp 0", out_fifo_we); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
        if (matrix_count !== 16'd0) begin errors++; $display("FAIL rst_matrix_count got %0d exp 0", matrix_count); end
        rst_n = 1'b1;
        wait_cycles(2);
    endtask

    task automatic test_flush_idle;
        int en0 = n_en;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks += 2;
        if (done !== 1'b1) begin errors++; $display("FAIL idle_flush_done got %b exp 1", done); end
        if (busy !== 1'b1) begin errors++; $display("FAIL idle_flush_busy got %b exp 1", busy); end
        @(negedge clk);
        checks += 4;
        if (done !== 1'b0) begin errors++; $display("FAIL idle_flush_done_width got %b exp 0", done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_flush_busy_fall got %b exp 0", busy); end
        if (n_en - en0 != 0) begin errors++; $display("FAIL idle_flush_core_en got %0d exp 0", n_en - en0); end
        if (matrix_count !== 16'd0) begin errors++; $display("FAIL idle_flush_mat got %0d exp 0", matrix_count); end
    endtask

    task automatic test_steady;
        int we0 = n_we, run = 0, t = 0;
        out_fifo_re = 1'b1;
        pushed += 64;
        while (!core_en && t < 20) begin @(negedge clk); t++; end
        while (core_en && run < 100) begin run++; @(negedge clk); end
        wait_cycles(3);
        checks += 4;
        if (run != 64) begin errors++; $display("FAIL steady_run got %0d exp 64", run); end
        if (n_we - we0 != 32) begin errors++; $display("FAIL steady_writes got %0d exp 32", n_we - we0); end
        if (matrix_count !== 16'd2) begin errors++; $display("FAIL steady_mat got %0d exp 2", matrix_count); end
        if (busy !== 1'b1) begin errors++; $display("FAIL steady_busy got %b exp 1", busy); end
    endtask

    task automatic test_flush_boundary;
        int en0 = n_en, we0 = n_we, z0 = n_zero, d0 = n_done, lat;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_done(100, lat);
        checks += 5;
        if (lat != 34) begin errors++; $display("FAIL drain_latency got %0d exp 34", lat); end
        if (n_zero - z0 != 32) begin errors++; $display("FAIL drain_zero_beats got %0d exp 32", n_zero - z0); end
        if (n_en - en0 != 32) begin errors++; $display("FAIL drain_core_en got %0d exp 32", n_en - en0); end
        if (n_we - we0 != 32) begin errors++; $display("FAIL drain_writes got %0d exp 32", n_we - we0); end
        if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy_done got %b exp 1", busy); end
        @(negedge clk);
        checks += 4;
        if (done !== 1'b0) begin errors++; $display("FAIL drain_done_width got %b exp 0", done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy_fall got %b exp 0", busy); end
        if (n_done - d0 != 1) begin errors++; $display("FAIL drain_done_pulses got %0d exp 1", n_done - d0); end
        if (matrix_count !== 16'd2) begin errors++; $display("FAIL drain_mat_kept got %0d exp 2", matrix_count); end
    endtask

    task automatic test_flush_mid;
        int z0 = n_zero, lat;
        pushed += 20;
        wait_cycles(25);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_cycles(10);
        checks += 3;
        if (n_zero - z0 != 0) begin errors++; $display("FAIL mid_no_drain got %0d exp 0", n_zero - z0); end
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL mid_done_early got %b exp 0", done); end
        pushed += 12;
        wait_done(100, lat);
        checks += 3;
        if (done !== 1'b1) begin errors++; $display("FAIL mid_done got %b exp 1", done); end
        if (n_zero - z0 != 32) begin errors++; $display("FAIL mid_zero_beats got %0d exp 32", n_zero - z0); end
        if (matrix_count !== 16'd3) begin errors++; $display("FAIL mid_mat got %0d exp 3", matrix_count); end
        wait_cycles(2);
    endtask

    task automatic test_back_pressure;
        int en0 = n_en, we0 = n_we, re0 = n_re;
        out_fifo_re = 1'b0;
        pushed += 40;
        wait_cycles(30);
        checks += 4;
        if (n_we - we0 != 8) begin errors++; $display("FAIL bp_writes got %0d exp 8", n_we - we0); end
        if (n_en - en0 != 8) begin errors++; $display("FAIL bp_beats got %0d exp 8", n_en - en0); end
        if (in_fifo_re !== 1'b0) begin errors++; $display("FAIL bp_in_fifo_re got %b exp 0", in_fifo_re); end
        if (ocnt != 8) begin errors++; $display("FAIL bp_occupancy got %0d exp 8", ocnt); end
        out_fifo_re = 1'b1;
        wait_cycles(80);
        checks += 4;
        if (n_en - en0 != 40) begin errors++; $display("FAIL bp_resume_beats got %0d exp 40", n_en - en0); end
        if (n_re - re0 != 40) begin errors++; $display("FAIL bp_resume_reads got %0d exp 40", n_re - re0); end
        if (matrix_count !== 16'd4) begin errors++; $display("FAIL bp_mat got %0d exp 4", matrix_count); end
        if (max_ocnt > 8) begin errors++; $display("FAIL bp_overflow got %0d exp <=8", max_ocnt); end
    endtask

    task automatic test_reset_mid;
        int t = 0, we0;
        out_fifo_re = 1'b0;
        pushed += 10;
        while (ocnt != 5 && t < 40) begin @(negedge clk); t++; end
        checks += 1;
        if (ocnt != 5) begin errors++; $display("FAIL rmid_reach_occ5 got %0d exp 5", ocnt); end
        rst_n = 1'b0;
        pushed = popped;
        #1;
        checks += 5;
        if (in_fifo_re !== 1'b0) begin errors++; $display("FAIL rmid_in_fifo_re got %b exp 0", in_fifo_re); end
        if (core_en !== 1'b0) begin errors++; $display("FAIL rmid_core_en got %b exp 0", core_en); end
        if (out_fifo_we !== 1'b0) begin errors++; $display("FAIL rmid_out_fifo_we got %b exp 0", out_fifo_we); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
        if (matrix_count !== 16'd0) begin errors++; $display("FAIL rmid_mat got %0d exp 0", matrix_count); end
        wait_cycles(2);
        rst_n = 1'b1;
        @(negedge clk);
        checks += 1;
        if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle_after got %b exp 0", busy); end
        force_valid = 1'b1;
        we0 = n_we;
        pushed += 12;
        wait_cycles(30);
        checks += 3;
        if (n_we - we0 != 8) begin errors++; $display("FAIL rmid_occ_cleared got %0d exp 8", n_we - we0); end
        if (ocnt != 8) begin errors++; $display("FAIL rmid_occupancy got %0d exp 8", ocnt); end
        if (max_ocnt > 8) begin errors++; $display("FAIL rmid_overflow got %0d exp <=8", max_ocnt); end
    endtask

    initial begin
        test_reset;
        test_flush_idle;
        test_steady;
        test_flush_boundary;
        test_flush_mid;
        test_back_pressure;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/transpose_stream_ctrl.md
# transpose_stream_ctrl

Flow controller that sequences the streaming 32x32 matrix transpose core between its 512-bit input FIFO and output FIFO. It pops input rows only when the output FIFO can absorb the result, gates the core's clock enable, counts rows and matrices, and on request drains the last in-flight matrix by feeding zero rows. It replaces the free-running read/enable logic in the accelerator user block, so back-pressure never overflows the output FIFO.

## Interface
- BEATS, 32, rows per matrix (core drain length)
- ROW_CNT_W, 5, width of row counter (log2 BEATS)
- OUT_DEPTH_BITS, 3, log2 of output FIFO depth
- MAT_CNT_W, 16, width of matrix counter
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- in_fifo_empty  in  1  input FIFO empty
- in_fifo_re  out  1  input FIFO read enable (sync-read FIFO: dout valid next cycle)
- core_en  out  1  drives core clk_en and start; one row accepted per high cycle
- core_zero  out  1  high with core_en during drain; datapath muxes zero row into core
- core_valid  in  1  core start_next_stage (output row valid when core_en high)
- out_fifo_we  out  1  output FIFO write enable
- out_fifo_re  in  1  downstream pop of output FIFO
- flush  in  1  single-cycle request: finish after current input is exhausted
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse when drain completes
- matrix_count  out  MAT_CNT_W  full input matrices consumed since reset

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset state IDLE.
- IDLE: in_fifo_re low. Go to RUN when in_fifo_empty low. A flush in IDLE with matrix_count 0 goes straight to DONE.
- credit_ok = (occ + core_en) < 2**OUT_DEPTH_BITS, where occ (OUT_DEPTH_BITS+1 bits) tracks output FIFO occupancy: +1 on out_fifo_we, -1 on out_fifo_re when occ != 0, both in same cycle -> unchanged. Every beat is counted as potentially writing.
- RUN: in_fifo_re = ~in_fifo_empty & credit_ok (combinational from registered state/counters). Each read is a beat.
- Beat bookkeeping on the core_en cycle: row_cnt increments, wraps BEATS-1 -> 0; on wrap in RUN matrix_count increments (wraps at 2**MAT_CNT_W).
- flush latches flush_pend (set in any state except DONE, cleared on DONE).
- RUN -> DRAIN when flush_pend & in_fifo_empty & row_cnt == 0 & ~core_en & ~in_fifo_re. A partial matrix (row_cnt != 0) waits in RUN for more input; flush never truncates.
- DRAIN: issue BEATS zero beats, each gated by credit_ok; core_zero high with each. drain_cnt counts them; after the BEATS-th beat go to DONE. Input FIFO is not read in DRAIN.
- DONE: done = 1 for exactly one cycle, flush_pend cleared, row_cnt cleared, then IDLE. matrix_count is not cleared.
- out_fifo_we = core_en & core_valid; zero-beat outputs in DRAIN are written normally (they carry the final transposed matrix).
- Async reset mid-operation: all state, counters, occ cleared immediately; FIFOs are reset by the same signal.

## Timing
- Reset values: in_fifo_re 0, core_en 0, core_zero 0, out_fifo_we 0, busy 0, done 0, matrix_count 0.
- core_en is a register: high the cycle after in_fifo_re (aligned with FIFO dout) or the cycle after a drain beat is issued.
- Throughput: one row per cycle when input non-empty and credit available; no bubble at matrix boundaries.
- Full output FIFO: in_fifo_re and drain issue drop in the same cycle credit_ok falls; at most one beat in flight, so occupancy never exceeds 2**OUT_DEPTH_BITS.
- RUN -> DRAIN decision takes one cycle after the last beat's core_en; DRAIN of BEATS rows with no back-pressure lasts BEATS cycles of core_en plus one cycle issue latency; done follows the last core_en by one cycle.
- busy high from first cycle out of IDLE through the DONE cycle.

## Test plan
- Reset: hold reset low mid-RUN with occ 5 -> all outputs 0, occ 0, state IDLE next cycle after release.
- Steady stream: 64 rows preloaded, out_fifo_re held high -> 64 consecutive core_en cycles, matrix_count 2, out_fifo_we on rows 33..64 only.
- Back-pressure: out_fifo_re held low -> exactly 8 out_fifo_we pulses then in_fifo_re stays 0; release out_fifo_re -> streaming resumes, no rows lost.
- Flush at boundary: 32 rows then flush -> DRAIN issues 32 core_zero beats, 32 writes of transposed matrix, done pulse one cycle, busy falls next cycle.
- Flush mid-matrix: 20 rows then flush -> stays RUN; 12 more rows then DRAIN; matrix_count 1.
- Flush with no data in IDLE -> done pulse next cycle, no core_en, matrix_count 0.
